// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Registered memory port, alternating tie-break, fetch cancel and one-cycle done pulses.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;
    logic             last_d;
    logic             killed;
    logic             if_ok, gnt_d, gnt_if, acc_last;

    // A cancelled fetch never competes; on a tie D wins unless it had the previous grant.
    assign if_ok    = if_req && !if_cancel;
    assign gnt_d    = d_req && !(if_ok && last_d);
    assign gnt_if   = if_ok && !gnt_d;
    assign acc_last = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_d || gnt_if) state_nxt = ACC;
            ACC:     if (acc_last)        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            killed    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_d || gnt_if) begin
                        owner_d  <= gnt_d;
                        last_d   <= gnt_d;
                        mem_en   <= 1'b1;
                        mem_wr   <= gnt_d && d_wr;
                        mem_addr <= gnt_d ? d_addr : if_addr;
                        if (gnt_d) mem_wdata <= d_wdata;
                        cnt      <= CNT_W'(LAT - 1);
                    end
                end
                ACC: begin
                    if (!owner_d && if_cancel) killed <= 1'b1;
                    if (!acc_last) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        if (owner_d) begin
                            d_done <= 1'b1;
                            if (!mem_wr) d_rdata <= mem_rdata;
                        end else if (!killed && !if_cancel) begin
                            // a cancel in the final access cycle also kills the fetch
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE:    killed <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=4 main instance plus a LAT=1 instance for the short-latency case.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_cancel, if_done, d_req, d_wr, d_done;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        l1_if_done, l1_d_req, l1_d_done, l1_mem_en, l1_mem_wr;
    logic [15:0] l1_if_rdata, l1_d_addr, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: 0x0010 holds 0xB123, every other address returns {a[11:4], 8'hC3}.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hB123 : {a[11:4], 8'hC3};
    endfunction

    assign mem_rdata    = mem_en    ? mem_model(mem_addr)    : 16'hDEAD;
    assign l1_mem_rdata = l1_mem_en ? mem_model(l1_mem_addr) : 16'hDEAD;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(16'h0000), .if_cancel(1'b0),
        .if_rdata(l1_if_rdata), .if_done(l1_if_done),
        .d_req(l1_d_req), .d_wr(1'b0), .d_addr(l1_d_addr), .d_wdata(16'h0000),
        .d_rdata(l1_d_rdata), .d_done(l1_d_done),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_cancel = 1'b0; if_addr = 16'h0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        l1_d_req = 1'b0; l1_d_addr = 16'h0;
        tick(); tick();

        chk("rst_ctl",   32'({mem_en, mem_wr, if_done, d_done}), 'h0);
        chk("rst_addr",  32'(mem_addr), 'h0);
        chk("rst_wdata", 32'(mem_wdata), 'h0);
        chk("rst_rdata", 32'({if_rdata, d_rdata}), 'h0);
        rst_n = 1'b1;
        tick();

        // LAT=1: grant, one access cycle, done
        l1_d_req = 1'b1; l1_d_addr = 16'h0010;
        tick();
        chk("l1_en", 32'(l1_mem_en), 'h1);
        chk("l1_nodone", 32'(l1_d_done), 'h0);
        tick();
        chk("l1_done", 32'(l1_d_done), 'h1);
        chk("l1_rdata", 32'(l1_d_rdata), 'hB123);
        chk("l1_en_off", 32'(l1_mem_en), 'h0);
        l1_d_req = 1'b0;
        tick();
        chk("l1_pulse", 32'(l1_d_done), 'h0);

        // single fetch
        if_req = 1'b1; if_addr = 16'h0010;
        chk("f1_c0_en", 32'(mem_en), 'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("f1_en", 32'(mem_en), 'h1);
            chk("f1_addr", 32'(mem_addr), 'h0010);
            chk("f1_wr", 32'(mem_wr), 'h0);
            chk("f1_early", 32'(if_done), 'h0);
        end
        tick();
        chk("f1_done", 32'(if_done), 'h1);
        chk("f1_rdata", 32'(if_rdata), 'hB123);
        chk("f1_en_off", 32'(mem_en), 'h0);
        if_req = 1'b0;
        tick();
        chk("f1_pulse", 32'(if_done), 'h0);

        // simultaneous: D first, then IF
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_addr = 16'h0100;
        tick();
        chk("sim_d_addr", 32'(mem_addr), 'h0100);
        repeat (3) tick();
        tick();
        chk("sim_d_done", 32'({d_done, if_done}), 'h2);
        chk("sim_d_rdata", 32'(d_rdata), 'h10C3);
        d_req = 1'b0;
        tick();
        chk("sim_c6_en", 32'(mem_en), 'h0);
        tick();
        chk("sim_c7_en", 32'(mem_en), 'h1);
        chk("sim_if_addr", 32'(mem_addr), 'h0010);
        repeat (3) tick();
        tick();
        chk("sim_if_done", 32'({d_done, if_done}), 'h1);
        chk("sim_if_rdata", 32'(if_rdata), 'hB123);
        if_req = 1'b0;
        tick();

        // alternation with both held: D, IF, D, IF
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_addr = 16'h0300;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_addr", 32'(mem_addr), (k % 2 == 0) ? 'h0300 : 'h0020);
            repeat (3) tick();
            tick();
            chk("alt_done", 32'({d_done, if_done}), (k % 2 == 0) ? 'h2 : 'h1);
            if (k % 2 == 0) chk("alt_d_rdata", 32'(d_rdata), 'h30C3);
            else            chk("alt_if_rdata", 32'(if_rdata), 'h02C3);
            if (k == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
        end

        // data write
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h5A5A;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("wr_en_wr", 32'({mem_en, mem_wr}), 'h3);
            chk("wr_addr", 32'(mem_addr), 'h0200);
            chk("wr_wdata", 32'(mem_wdata), 'h5A5A);
        end
        tick();
        chk("wr_done", 32'(d_done), 'h1);
        chk("wr_rdata_kept", 32'(d_rdata), 'h30C3);
        chk("wr_strobe_off", 32'({mem_en, mem_wr}), 'h0);
        d_req = 1'b0; d_wr = 1'b0;
        tick();

        // fetch cancel in cycle 2
        if_req = 1'b1; if_addr = 16'h0040;
        tick();
        tick();
        if_cancel = 1'b1; if_req = 1'b0;
        chk("cx_c2_en", 32'(mem_en), 'h1);
        tick();
        if_cancel = 1'b0;
        chk("cx_c3_en", 32'(mem_en), 'h1);
        tick();
        chk("cx_c4_en", 32'(mem_en), 'h1);
        tick();
        chk("cx_no_done", 32'(if_done), 'h0);
        chk("cx_rdata_kept", 32'(if_rdata), 'h02C3);
        chk("cx_c5_en", 32'(mem_en), 'h0);
        tick();
        if_req = 1'b1; if_addr = 16'h0040;
        tick();
        chk("cx_regrant", 32'({mem_en, mem_addr}), 'h10040);
        repeat (3) tick();
        tick();
        chk("cx_refetch_done", 32'(if_done), 'h1);
        chk("cx_refetch_rdata", 32'(if_rdata), 'h04C3);
        if_req = 1'b0;
        tick();

        // if_req with if_cancel in IDLE is never granted
        if_req = 1'b1; if_cancel = 1'b1; if_addr = 16'h0050;
        tick();
        chk("cxi_en1", 32'(mem_en), 'h0);
        tick();
        chk("cxi_en2", 32'(mem_en), 'h0);
        if_req = 1'b0; if_cancel = 1'b0;
        tick();

        // reset in cycle 2 of a D read
        d_req = 1'b1; d_addr = 16'h0100;
        tick();
        chk("rm_c1_en", 32'(mem_en), 'h1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rm_ctl", 32'({mem_en, mem_wr, if_done, d_done}), 'h0);
        chk("rm_addr", 32'(mem_addr), 'h0);
        chk("rm_wdata", 32'(mem_wdata), 'h0);
        chk("rm_rdata", 32'({if_rdata, d_rdata}), 'h0);
        rst_n = 1'b1; d_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rm_no_done", 32'({mem_en, d_done}), 'h0);
        end
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_addr = 16'h0100;
        tick();
        chk("rm_tie_d", 32'(mem_addr), 'h0100);
        repeat (3) tick();
        tick();
        chk("rm_tie_done", 32'({d_done, if_done}), 'h2);
        chk("rm_tie_rdata", 32'(d_rdata), 'h10C3);
        if_req = 1'b0; d_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
